// File: rtl/fft_pkg.sv
// Shared FFT datapath types: butterfly mode encoding and the scale/saturate helper
// used by every complex adder lane.
package fft_pkg;

    typedef enum logic {
        MODE_BFLY = 1'b0,
        MODE_MOD  = 1'b1
    } mode_e;

    // Widest sample the helper supports; sums carry one extra guard bit.
    localparam int unsigned MAX_W = 32;
    localparam int unsigned SUM_W = MAX_W + 1;

    typedef logic signed [SUM_W-1:0] sum_t;

    typedef struct packed {
        logic signed [MAX_W-1:0] val;
        logic                    ovf;
    } sat_t;

    // Halve (optionally round-half-up) or clip a w+1-bit sum back into w bits.
    function automatic sat_t sat_round(input sum_t sum, input int unsigned w,
                                       input logic scale, input logic rnd);
        sat_t r;
        sum_t hi;
        sum_t lo;
        sum_t t;
        hi = (sum_t'(1) <<< (w - 1)) - sum_t'(1);
        lo = -(sum_t'(1) <<< (w - 1));
        r  = '0;
        t  = sum;
        if (scale) begin
            t = (sum + (rnd ? sum_t'(1) : sum_t'(0))) >>> 1;
        end else if (sum > hi) begin
            t     = hi;
            r.ovf = 1'b1;
        end else if (sum < lo) begin
            t     = lo;
            r.ovf = 1'b1;
        end
        r.val = t[MAX_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/butterfly_adder_pipe_if.sv
// Input-triple and output-pair handshake bundle for butterfly_adder_pipe.
interface butterfly_adder_pipe_if #(
    parameter int unsigned bit_width = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        en_modify;
    logic                        scale;
    logic signed [bit_width-1:0] xin1, yin1, xin2, yin2, xin3, yin3;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [bit_width-1:0] xout1, yout1, xout2, yout2;
    logic                        ovf;
    logic                        ovf_clr;

    modport master (
        output in_valid, en_modify, scale, xin1, yin1, xin2, yin2, xin3, yin3,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, xout1, yout1, xout2, yout2, ovf
    );

    modport slave (
        input  in_valid, en_modify, scale, xin1, yin1, xin2, yin2, xin3, yin3,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, xout1, yout1, xout2, yout2, ovf
    );
endinterface

// File: rtl/butterfly_adder_pipe_cplx_sat_add.sv
// One complex add/subtract lane with optional halving and saturation.
module cplx_sat_add
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 16,
    parameter bit          ROUND     = 1'b1
) (
    input  logic signed [bit_width-1:0] re_a,
    input  logic signed [bit_width-1:0] im_a,
    input  logic signed [bit_width-1:0] re_b,
    input  logic signed [bit_width-1:0] im_b,
    input  logic                        sub,
    input  logic                        scale,
    output logic signed [bit_width-1:0] re_s,
    output logic signed [bit_width-1:0] im_s,
    output logic                        ovf
);
    sum_t re_sum;
    sum_t im_sum;
    sat_t re_r;
    sat_t im_r;

    always_comb begin
        re_sum = sub ? sum_t'(re_a) - sum_t'(re_b) : sum_t'(re_a) + sum_t'(re_b);
        im_sum = sub ? sum_t'(im_a) - sum_t'(im_b) : sum_t'(im_a) + sum_t'(im_b);
        re_r   = sat_round(re_sum, bit_width, scale, ROUND);
        im_r   = sat_round(im_sum, bit_width, scale, ROUND);
    end

    assign re_s = re_r.val[bit_width-1:0];
    assign im_s = im_r.val[bit_width-1:0];
    assign ovf  = re_r.ovf | im_r.ovf;

    generate
        if (bit_width < MAX_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^{re_r.val[MAX_W-1:bit_width], im_r.val[MAX_W-1:bit_width]};
        end
    endgenerate
endmodule

// File: rtl/butterfly_adder_pipe.sv
// Two-stage registered FFT butterfly adder with valid/ready backpressure,
// optional divide-by-2 scaling, saturation and a sticky overflow flag.
module butterfly_adder_pipe
    import fft_pkg::*;
#(
    parameter int unsigned bit_width = 16,
    parameter bit          ROUND     = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    butterfly_adder_pipe_if.slave bus
);
    logic                        s1_valid;
    mode_e                       s1_mode;
    logic                        s1_scale;
    logic signed [bit_width-1:0] s1_x1, s1_y1, s1_x2, s1_y2, s1_x3, s1_y3;

    logic                        s2_adv;
    logic                        in_ready;
    logic                        s2_load;

    logic signed [bit_width-1:0] sum_x, sum_y, dif_x, dif_y;
    logic                        sum_ovf, dif_ovf;
    logic signed [bit_width-1:0] dif_bx, dif_by;
    logic                        dif_sub;

    // S1 advances exactly when S2 does, so in_ready never depends on in_valid.
    assign s2_adv       = !bus.out_valid || bus.out_ready;
    assign in_ready     = !s1_valid || s2_adv;
    assign bus.in_ready = in_ready;
    assign s2_load      = s2_adv && s1_valid;

    assign dif_bx  = (s1_mode == MODE_MOD) ? s1_x3 : s1_x2;
    assign dif_by  = (s1_mode == MODE_MOD) ? s1_y3 : s1_y2;
    assign dif_sub = (s1_mode == MODE_BFLY);

    cplx_sat_add #(.bit_width(bit_width), .ROUND(ROUND)) u_sum (
        .re_a (s1_x1),
        .im_a (s1_y1),
        .re_b (s1_x2),
        .im_b (s1_y2),
        .sub  (1'b0),
        .scale(s1_scale),
        .re_s (sum_x),
        .im_s (sum_y),
        .ovf  (sum_ovf)
    );

    cplx_sat_add #(.bit_width(bit_width), .ROUND(ROUND)) u_dif (
        .re_a (s1_x1),
        .im_a (s1_y1),
        .re_b (dif_bx),
        .im_b (dif_by),
        .sub  (dif_sub),
        .scale(s1_scale),
        .re_s (dif_x),
        .im_s (dif_y),
        .ovf  (dif_ovf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_mode       <= MODE_BFLY;
            s1_scale      <= 1'b0;
            s1_x1         <= '0;
            s1_y1         <= '0;
            s1_x2         <= '0;
            s1_y2         <= '0;
            s1_x3         <= '0;
            s1_y3         <= '0;
            bus.out_valid <= 1'b0;
            bus.xout1     <= '0;
            bus.yout1     <= '0;
            bus.xout2     <= '0;
            bus.yout2     <= '0;
            bus.ovf       <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_mode  <= mode_e'(bus.en_modify);
                    s1_scale <= bus.scale;
                    s1_x1    <= bus.xin1;
                    s1_y1    <= bus.yin1;
                    s1_x2    <= bus.xin2;
                    s1_y2    <= bus.yin2;
                    s1_x3    <= bus.xin3;
                    s1_y3    <= bus.yin3;
                end
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
            end
            if (s2_load) begin
                bus.xout1 <= sum_x;
                bus.yout1 <= sum_y;
                bus.xout2 <= dif_x;
                bus.yout2 <= dif_y;
            end
            // A clip on the same cycle as ovf_clr wins over the clear.
            if (bus.ovf_clr) begin
                bus.ovf <= 1'b0;
            end
            if (s2_load && (sum_ovf || dif_ovf)) begin
                bus.ovf <= 1'b1;
            end
        end
    end
endmodule
